// File: rtl/wb_spi_sram.sv
// Wishbone classic slave that turns single-byte accesses into mode-0 SPI SRAM READ/WRITE transactions.
// Define WB_SPI_SRAM_FAST_READ_EN to issue FAST READ (0x0B) with eight dummy bits on reads.
module wb_spi_sram #(
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 8,
   parameter int SEL_WIDTH  = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   input  logic [ADDR_WIDTH-1:0] wb_adr_i,
   input  logic                  wb_we_i,
   input  logic [SEL_WIDTH-1:0]  wb_sel_i,
   input  logic [DATA_WIDTH-1:0] wb_dat_i,
   output logic                  wb_ack_o,
   output logic                  wb_err_o,
   output logic                  wb_rty_o,
   output logic [DATA_WIDTH-1:0] wb_dat_o,
   output logic                  spi_sck_o,
   output logic                  spi_cs_n_o,
   output logic                  spi_mosi_o,
   input  logic                  spi_miso_i
);

   localparam int CW = $clog2(ADDR_WIDTH);

`ifdef WB_SPI_SRAM_FAST_READ_EN
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE} state_t;
   localparam logic [7:0] READ_CMD = 8'h0B;
`else
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;
   localparam logic [7:0] READ_CMD = 8'h03;
`endif

   state_t                state;
   logic [CW-1:0]         bit_cnt;
   logic [CW-1:0]         last_bit;
   logic [ADDR_WIDTH-1:0] adr_q;
   logic [ADDR_WIDTH-1:0] tx;
   logic                  we_q;
   logic [7:0]            dat_q;
   logic [6:0]            rx;
   logic [7:0]            rx_next;
   logic [7:0]            cmd_byte;
   logic [7:0]            data_byte;
   logic                  unused_sel;

   assign wb_err_o   = 1'b0;
   assign wb_rty_o   = 1'b0;
   assign unused_sel = ^wb_sel_i;
   assign cmd_byte   = wb_we_i ? 8'h02 : READ_CMD;
   assign data_byte  = we_q ? dat_q : 8'h00;
   assign rx_next    = {rx, spi_miso_i};
   assign last_bit   = (state == ADDR) ? CW'(ADDR_WIDTH - 1) : CW'(7);

   // tx holds the bits still to be sent; the MSB of each field is loaded straight into spi_mosi_o.
   // Each bit spends one cycle with SCK low and one with SCK high; MISO is taken as SCK falls.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         adr_q      <= '0;
         tx         <= '0;
         we_q       <= 1'b0;
         dat_q      <= '0;
         rx         <= '0;
         spi_cs_n_o <= 1'b1;
         spi_sck_o  <= 1'b0;
         spi_mosi_o <= 1'b0;
         wb_ack_o   <= 1'b0;
         wb_dat_o   <= '0;
      end else begin
         wb_ack_o <= 1'b0;
         case (state)
            IDLE: begin
               if (wb_cyc_i && wb_stb_i) begin
                  adr_q      <= wb_adr_i;
                  we_q       <= wb_we_i;
                  dat_q      <= wb_dat_i[7:0];
                  state      <= CMD;
                  bit_cnt    <= '0;
                  spi_cs_n_o <= 1'b0;
                  spi_sck_o  <= 1'b0;
                  spi_mosi_o <= cmd_byte[7];
                  tx         <= {cmd_byte[6:0], {(ADDR_WIDTH - 7){1'b0}}};
               end
            end
            DONE: state <= IDLE;
            default: begin
               if (!wb_cyc_i) begin
                  state      <= IDLE;
                  bit_cnt    <= '0;
                  spi_cs_n_o <= 1'b1;
                  spi_sck_o  <= 1'b0;
                  spi_mosi_o <= 1'b0;
               end else if (!spi_sck_o) begin
                  spi_sck_o <= 1'b1;
               end else begin
                  spi_sck_o <= 1'b0;
                  rx        <= rx_next[6:0];
                  if (bit_cnt != last_bit) begin
                     bit_cnt    <= bit_cnt + 1'b1;
                     spi_mosi_o <= tx[ADDR_WIDTH-1];
                     tx         <= tx << 1;
                  end else begin
                     bit_cnt <= '0;
                     case (state)
                        CMD: begin
                           state      <= ADDR;
                           spi_mosi_o <= adr_q[ADDR_WIDTH-1];
                           tx         <= {adr_q[ADDR_WIDTH-2:0], 1'b0};
                        end
                        ADDR: begin
`ifdef WB_SPI_SRAM_FAST_READ_EN
                           if (!we_q) begin
                              state      <= DUMMY;
                              spi_mosi_o <= 1'b0;
                              tx         <= '0;
                           end else
`endif
                           begin
                              state      <= DATA;
                              spi_mosi_o <= data_byte[7];
                              tx         <= {data_byte[6:0], {(ADDR_WIDTH - 7){1'b0}}};
                           end
                        end
`ifdef WB_SPI_SRAM_FAST_READ_EN
                        DUMMY: begin
                           state      <= DATA;
                           spi_mosi_o <= data_byte[7];
                           tx         <= {data_byte[6:0], {(ADDR_WIDTH - 7){1'b0}}};
                        end
`endif
                        DATA: begin
                           state      <= DONE;
                           spi_cs_n_o <= 1'b1;
                           spi_mosi_o <= 1'b0;
                           wb_ack_o   <= 1'b1;
                           if (!we_q) begin
                              wb_dat_o <= DATA_WIDTH'(rx_next);
                           end
                        end
                        default: state <= IDLE;
                     endcase
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_spi_sram.sv
// Directed bench for wb_spi_sram: drives Wishbone requests against a small mode-0 SPI SRAM model.
// Build with WB_SPI_SRAM_FAST_READ_EN to expect FAST READ timing and command.
module tb_wb_spi_sram;

`ifdef WB_SPI_SRAM_FAST_READ_EN
   localparam int         RD_ACK       = 97;
   localparam int         RD_DATA_BASE = 40;
   localparam logic [7:0] RD_CMD       = 8'h0B;
`else
   localparam int         RD_ACK       = 81;
   localparam int         RD_DATA_BASE = 32;
   localparam logic [7:0] RD_CMD       = 8'h03;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        we  = 1'b0;
   logic [23:0] adr = '0;
   logic [0:0]  sel = 1'b1;
   logic [7:0]  dat_w = '0;
   logic        ack, err, rty;
   logic [7:0]  dat_r;
   logic        sck, cs_n, mosi;
   logic        miso;

   int          checks = 0;
   int          passes = 0;

   always #5 clk = ~clk;

   wb_spi_sram #(.ADDR_WIDTH(24), .DATA_WIDTH(8), .SEL_WIDTH(1)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .wb_cyc_i   (cyc),
      .wb_stb_i   (stb),
      .wb_adr_i   (adr),
      .wb_we_i    (we),
      .wb_sel_i   (sel),
      .wb_dat_i   (dat_w),
      .wb_ack_o   (ack),
      .wb_err_o   (err),
      .wb_rty_o   (rty),
      .wb_dat_o   (dat_r),
      .spi_sck_o  (sck),
      .spi_cs_n_o (cs_n),
      .spi_mosi_o (mosi),
      .spi_miso_i (miso)
   );

   // SRAM model: records every MOSI bit on SCK rise and serves sram_byte during the data phase.
   int          sck_rises = 0;
   logic [63:0] mosi_sr   = '0;
   int          rise_base = 0;
   int          rel_rise;
   logic [7:0]  sram_byte = '0;
   logic        sck_cs_bad = 1'b0;

   always @(posedge sck) begin
      sck_rises <= sck_rises + 1;
      mosi_sr   <= {mosi_sr[62:0], mosi};
   end

   assign rel_rise = sck_rises - rise_base;

   always_comb begin
      miso = 1'b0;
      if (rel_rise > RD_DATA_BASE && rel_rise <= RD_DATA_BASE + 8) begin
         miso = sram_byte[3'(RD_DATA_BASE + 8 - rel_rise)];
      end
   end

   always @(negedge clk) begin
      if (cs_n === 1'b1 && sck === 1'b1) sck_cs_bad <= 1'b1;
   end

   // Transaction driver: request in cycle 0, observe each later cycle #1 after its opening edge.
   int   ack_cyc;
   int   rise_cnt;
   logic [7:0] ack_dat;
   logic cs_hist [0:127];

   task automatic run_txn(input logic t_we, input logic [23:0] t_adr, input logic [7:0] t_dat,
                          input int drop_at, input int budget, input logic hold);
      ack_cyc = 0;
      ack_dat = '0;
      for (int i = 0; i < 128; i++) cs_hist[i] = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      cyc       = 1'b1;
      stb       = 1'b1;
      we        = t_we;
      adr       = t_adr;
      dat_w     = t_dat;
      rise_base = sck_rises;
      cs_hist[0] = cs_n;
      for (int k = 1; k <= budget; k++) begin
         @(posedge clk);
         #1;
         if (k < 128) cs_hist[k] = cs_n;
         if (ack === 1'b1) begin
            ack_cyc = k;
            ack_dat = dat_r;
            break;
         end
         if (k == drop_at) begin
            cyc = 1'b0;
            stb = 1'b0;
         end
      end
      rise_cnt = sck_rises - rise_base;
      if (!hold) begin
         cyc = 1'b0;
         stb = 1'b0;
         we  = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #2;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({cs_n, sck, mosi, ack, err, rty} !== 6'b100000)
         $display("[TB] FAIL reset_outputs: got %b expected 100000", {cs_n, sck, mosi, ack, err, rty});
      else passes++;
      checks++;
      if (dat_r !== 8'h00) $display("[TB] FAIL reset_dat: got %h expected 00", dat_r);
      else passes++;
      run_txn(1'b1, 24'h000010, 8'h5C, 0, 100, 1'b0);
      checks++;
      if (cs_hist[1] !== 1'b0) $display("[TB] FAIL first_accept: cs_n at cycle 1 got %b expected 0", cs_hist[1]);
      else passes++;
      checks++;
      if (ack_cyc !== 81) $display("[TB] FAIL first_ack: got cycle %0d expected 81", ack_cyc);
      else passes++;
   endtask

   task automatic test_write();
      run_txn(1'b1, 24'h000123, 8'hA5, 0, 100, 1'b0);
      checks++;
      if (ack_cyc !== 81) $display("[TB] FAIL write_ack: got cycle %0d expected 81", ack_cyc);
      else passes++;
      checks++;
      if (mosi_sr[39:0] !== 40'h02000123A5) $display("[TB] FAIL write_mosi: got %h expected 02000123a5", mosi_sr[39:0]);
      else passes++;
      checks++;
      if (rise_cnt !== 40) $display("[TB] FAIL write_rises: got %0d expected 40", rise_cnt);
      else passes++;
      checks++;
      if ({cs_hist[80], cs_hist[81]} !== 2'b01)
         $display("[TB] FAIL write_cs_end: got %b expected 01", {cs_hist[80], cs_hist[81]});
      else passes++;
      @(posedge clk);
      #1;
      checks++;
      if (ack !== 1'b0) $display("[TB] FAIL ack_single: got %b expected 0", ack);
      else passes++;
      checks++;
      if (dat_r !== 8'h00) $display("[TB] FAIL write_keeps_dat: got %h expected 00", dat_r);
      else passes++;
   endtask

   task automatic test_read(input logic [23:0] t_adr, input logic [7:0] t_byte);
      sram_byte = t_byte;
      run_txn(1'b0, t_adr, 8'h00, 0, 120, 1'b0);
      checks++;
      if (ack_cyc !== RD_ACK) $display("[TB] FAIL read_ack: got cycle %0d expected %0d", ack_cyc, RD_ACK);
      else passes++;
      checks++;
      if (ack_dat !== t_byte) $display("[TB] FAIL read_data: got %h expected %h", ack_dat, t_byte);
      else passes++;
      checks++;
      if (mosi_sr[RD_DATA_BASE+7 -: 32] !== {RD_CMD, t_adr})
         $display("[TB] FAIL read_mosi: got %h expected %h", mosi_sr[RD_DATA_BASE+7 -: 32], {RD_CMD, t_adr});
      else passes++;
`ifdef WB_SPI_SRAM_FAST_READ_EN
      checks++;
      if (mosi_sr[15:8] !== 8'h00) $display("[TB] FAIL read_dummy: got %h expected 00", mosi_sr[15:8]);
      else passes++;
`endif
      checks++;
      if (rise_cnt !== RD_DATA_BASE + 8)
         $display("[TB] FAIL read_rises: got %0d expected %0d", rise_cnt, RD_DATA_BASE + 8);
      else passes++;
   endtask

   task automatic test_abort();
      sram_byte = 8'hFF;
      run_txn(1'b0, 24'h000200, 8'h00, 30, 100, 1'b0);
      checks++;
      if ({cs_hist[30], cs_hist[31]} !== 2'b01)
         $display("[TB] FAIL abort_cs: got %b expected 01", {cs_hist[30], cs_hist[31]});
      else passes++;
      checks++;
      if (ack_cyc !== 0) $display("[TB] FAIL abort_no_ack: got ack at cycle %0d expected none", ack_cyc);
      else passes++;
      checks++;
      if (dat_r !== 8'h5A) $display("[TB] FAIL abort_dat: got %h expected 5a", dat_r);
      else passes++;
   endtask

   task automatic test_back_to_back();
      run_txn(1'b1, 24'h000001, 8'h77, 0, 100, 1'b1);
      checks++;
      if (ack_cyc !== 81) $display("[TB] FAIL b2b_first_ack: got cycle %0d expected 81", ack_cyc);
      else passes++;
      run_txn(1'b1, 24'h000002, 8'h88, 0, 100, 1'b0);
      checks++;
      if ({cs_hist[0], cs_hist[1]} !== 2'b10)
         $display("[TB] FAIL b2b_cs_gap: got %b expected 10", {cs_hist[0], cs_hist[1]});
      else passes++;
      checks++;
      if (ack_cyc !== 81) $display("[TB] FAIL b2b_second_ack: got cycle %0d expected 81", ack_cyc);
      else passes++;
      checks++;
      if (mosi_sr[39:0] !== 40'h0200000288) $display("[TB] FAIL b2b_mosi: got %h expected 0200000288", mosi_sr[39:0]);
      else passes++;
      checks++;
      if (dat_r !== 8'h5A) $display("[TB] FAIL b2b_keeps_dat: got %h expected 5a", dat_r);
      else passes++;
   endtask

   task automatic test_reset_mid_write();
      @(posedge clk);
      #1;
      cyc   = 1'b1;
      stb   = 1'b1;
      we    = 1'b1;
      adr   = 24'h00ABCD;
      dat_w = 8'h11;
      for (int k = 1; k <= 50; k++) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if ({cs_n, sck} !== 2'b01) $display("[TB] FAIL midreset_before: got %b expected 01", {cs_n, sck});
      else passes++;
      rst = 1'b1;
      #1;
      checks++;
      if ({cs_n, sck, mosi, ack} !== 4'b1000)
         $display("[TB] FAIL midreset_outputs: got %b expected 1000", {cs_n, sck, mosi, ack});
      else passes++;
      checks++;
      if (dat_r !== 8'h00) $display("[TB] FAIL midreset_dat: got %h expected 00", dat_r);
      else passes++;
      cyc = 1'b0;
      stb = 1'b0;
      repeat (2) @(posedge clk);
      run_txn(1'b1, 24'h00ABCD, 8'h11, 0, 100, 1'b0);
      checks++;
      if (ack_cyc !== 81) $display("[TB] FAIL midreset_next_ack: got cycle %0d expected 81", ack_cyc);
      else passes++;
      checks++;
      if (mosi_sr[39:0] !== 40'h0200ABCD11) $display("[TB] FAIL midreset_next_mosi: got %h expected 0200abcd11", mosi_sr[39:0]);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read(24'hFFFFFE, 8'h3C);
      test_read(24'h000010, 8'h5A);
      test_abort();
      test_back_to_back();
      test_reset_mid_write();
      repeat (3) @(posedge clk);
      checks++;
      if (sck_cs_bad !== 1'b0) $display("[TB] FAIL sck_idle_low: got %b expected 0", sck_cs_bad);
      else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
